row_shift_loader: RTL and testbench

Responder end of the turn timer's `rowChange`/`rowChangeAck` row-advance handshake. On each request it latches the current row and fetches that row's `NUM_LEDS` pixels from frame memory, which has a fixed 1-cycle read latency. It shifts the pixels MSB-LED-first into the LED driver chain, pulses the chain latch, then acknowledges. It sits between the turn timer and the LED driver pins, with frame memory on its read port.

---
 rtl/row_shift_loader.sv | 142 ++++++++++++++
 tb/tb_row_shift_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/row_shift_loader.sv
`default_nettype none
// ============================================================================
// Module   : row_shift_loader
// Brief    : Fetches one row of pixels from frame memory on a row-advance
//            request, shifts it MSB-LED-first into the LED driver chain,
//            pulses the latch and acknowledges the request.
// Revision : 1.0
// ============================================================================
module row_shift_loader #(
    parameter int IMG_HEIGHT = 64,
    parameter int NUM_LEDS   = 32,
    parameter int PIX_W      = 3,
    parameter int SCLK_DIV   = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [$clog2(IMG_HEIGHT)-1:0]         row,
    input  logic                                  rowChange,
    output logic                                  rowChangeAck,
    output logic                                  memRd,
    output logic [$clog2(IMG_HEIGHT*NUM_LEDS)-1:0] memAddr,
    input  logic [PIX_W-1:0]                      memData,
    output logic [PIX_W-1:0]                      sdo,
    output logic                                  sclk,
    output logic                                  latch,
    output logic                                  busy
);

    localparam int c_ROW_W  = $clog2(IMG_HEIGHT);
    localparam int c_ADDR_W = $clog2(IMG_HEIGHT * NUM_LEDS);
    localparam int c_LED_W  = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int c_CNT_W  = $clog2(SCLK_DIV + 1);

    localparam logic [c_LED_W-1:0] c_LED_MAX  = c_LED_W'(NUM_LEDS - 1);
    localparam logic [c_CNT_W-1:0] c_HALF_END = c_CNT_W'(SCLK_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_LAT_END  = c_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_LOAD     = 3'd2,
        S_CLK_LO   = 3'd3,
        S_CLK_HI   = 3'd4,
        S_LATCH    = 3'd5,
        S_ACK      = 3'd6,
        S_WAIT_LOW = 3'd7
    } t_state;

    t_state              r_state;
    t_state              w_next_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_ROW_W-1:0]  r_row_lat;
    logic [c_LED_W-1:0]  r_led_idx;
    logic [c_ADDR_W-1:0] r_mem_addr;
    logic [PIX_W-1:0]    r_sdo;
    logic                r_mem_rd;
    logic                r_sclk;
    logic                r_latch;
    logic                r_ack;
    logic                r_busy;

    logic                w_half_done;
    logic                w_latch_done;
    logic [c_ROW_W-1:0]  w_addr_row;
    logic [c_LED_W-1:0]  w_addr_led;
    logic [c_ADDR_W-1:0] w_next_addr;

    assign w_half_done  = (r_cnt == c_HALF_END);
    assign w_latch_done = (r_cnt == c_LAT_END);

    // The address is formed one cycle early so it is already registered in READ;
    // from IDLE it uses the live row, afterwards the latched row and next LED.
    always_comb begin
        w_addr_row  = (r_state == S_IDLE) ? row : r_row_lat;
        w_addr_led  = (r_state == S_IDLE) ? c_LED_MAX : (r_led_idx - c_LED_W'(1));
        w_next_addr = c_ADDR_W'(w_addr_row) * c_ADDR_W'(NUM_LEDS) + c_ADDR_W'(w_addr_led);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (rowChange) w_next_state = S_READ;
            S_READ:     w_next_state = S_LOAD;
            S_LOAD:     w_next_state = S_CLK_LO;
            S_CLK_LO:   if (w_half_done) w_next_state = S_CLK_HI;
            S_CLK_HI:   if (w_half_done) w_next_state = (r_led_idx == '0) ? S_LATCH : S_READ;
            S_LATCH:    if (w_latch_done) w_next_state = S_ACK;
            S_ACK:      w_next_state = S_WAIT_LOW;
            S_WAIT_LOW: if (!rowChange) w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state value so each is a clean flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_row_lat  <= '0;
            r_led_idx  <= '0;
            r_mem_addr <= '0;
            r_sdo      <= '0;
            r_mem_rd   <= 1'b0;
            r_sclk     <= 1'b0;
            r_latch    <= 1'b0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_cnt    <= (w_next_state != r_state) ? '0 : (r_cnt + c_CNT_W'(1));
            r_mem_rd <= (w_next_state == S_READ);
            r_sclk   <= (w_next_state == S_CLK_HI);
            r_latch  <= (w_next_state == S_LATCH);
            r_ack    <= (w_next_state == S_ACK);
            r_busy   <= (w_next_state != S_IDLE);

            if (r_state == S_IDLE && rowChange) begin
                r_row_lat <= row;
                r_led_idx <= c_LED_MAX;
            end
            if (r_state == S_CLK_HI && w_half_done && r_led_idx != '0) begin
                r_led_idx <= r_led_idx - c_LED_W'(1);
            end
            if (w_next_state == S_READ) begin
                r_mem_addr <= w_next_addr;
            end
            if (r_state == S_LOAD) begin
                r_sdo <= memData;
            end
        end
    end

    assign rowChangeAck = r_ack;
    assign memRd        = r_mem_rd;
    assign memAddr      = r_mem_addr;
    assign sdo          = r_sdo;
    assign sclk         = r_sclk;
    assign latch        = r_latch;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_row_shift_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_row_shift_loader
// Brief    : Scoreboard bench for row_shift_loader (small and default configs).
// Revision : 1.0
// ============================================================================
module tb_row_shift_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       reset;
    logic [2:0] row;
    logic       row_change;
    logic       ack, mem_rd, sclk, latch, busy;
    logic [4:0] mem_addr;
    logic [2:0] mem_data = '0;
    logic [2:0] sdo;

    logic [5:0]  d_row;
    logic        d_row_change;
    logic        d_ack, d_mem_rd, d_sclk, d_latch, d_busy;
    logic [10:0] d_mem_addr;
    logic [2:0]  d_mem_data = '0;
    logic [2:0]  d_sdo;

    row_shift_loader #(.IMG_HEIGHT(8), .NUM_LEDS(4), .PIX_W(3), .SCLK_DIV(1)) dut (
        .clk(clk), .reset(reset), .row(row), .rowChange(row_change),
        .rowChangeAck(ack), .memRd(mem_rd), .memAddr(mem_addr), .memData(mem_data),
        .sdo(sdo), .sclk(sclk), .latch(latch), .busy(busy)
    );

    row_shift_loader dut_def (
        .clk(clk), .reset(reset), .row(d_row), .rowChange(d_row_change),
        .rowChangeAck(d_ack), .memRd(d_mem_rd), .memAddr(d_mem_addr), .memData(d_mem_data),
        .sdo(d_sdo), .sclk(d_sclk), .latch(d_latch), .busy(d_busy)
    );

    // Frame memory: word at addr is addr[2:0], one cycle read latency
    always @(posedge clk) begin
        if (mem_rd)   mem_data   <= mem_addr[2:0];
        if (d_mem_rd) d_mem_data <= d_mem_addr[2:0];
    end

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(string name, int act);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event, value %0d at cycle %0d", name, act, cyc);
    endfunction

    int q_rd_addr[$], q_rd_cyc[$], q_sdo[$], q_latch[$], q_ack[$];
    int q2_sdo[$], q2_latch[$], q2_ack[$];

    task automatic push_row(input int t0, input int r);
        for (int k = 0; k < 4; k++) begin
            q_rd_cyc.push_back(t0 + 1 + 4 * k);
            q_rd_addr.push_back(r * 4 + (3 - k));
            q_sdo.push_back((r * 4 + (3 - k)) & 7);
        end
        q_latch.push_back(t0 + 17);
        q_ack.push_back(t0 + 19);
    endtask

    // Monitor for the small configuration
    logic sclk_q = 1'b0, latch_q = 1'b0;
    int   latch_len = 0;
    always @(negedge clk) begin
        if (mem_rd) begin
            if (q_rd_addr.size() == 0) unexpected("rd", int'(mem_addr));
            else begin
                chk("rd_addr", int'(mem_addr), q_rd_addr.pop_front());
                chk("rd_cycle", cyc, q_rd_cyc.pop_front());
            end
        end
        if (sclk && !sclk_q) begin
            if (q_sdo.size() == 0) unexpected("sclk_rise", int'(sdo));
            else chk("sdo_at_rise", int'(sdo), q_sdo.pop_front());
        end
        if (latch && !latch_q) begin
            if (q_latch.size() == 0) unexpected("latch", cyc);
            else chk("latch_start", cyc, q_latch.pop_front());
            latch_len <= 1;
        end else if (latch) begin
            latch_len <= latch_len + 1;
        end
        if (!latch && latch_q) chk("latch_width", latch_len, 2);
        if (ack) begin
            if (q_ack.size() == 0) unexpected("ack", cyc);
            else chk("ack_cycle", cyc, q_ack.pop_front());
        end
        sclk_q  <= sclk;
        latch_q <= latch;
    end

    // Monitor for the default configuration
    logic d_sclk_q = 1'b0, d_latch_q = 1'b0;
    int   d_latch_len = 0, d_rises = 0, d_pulses = 0;
    always @(negedge clk) begin
        if (d_sclk && !d_sclk_q) begin
            d_rises <= d_rises + 1;
            if (q2_sdo.size() == 0) unexpected("def_sclk_rise", int'(d_sdo));
            else chk("def_sdo_at_rise", int'(d_sdo), q2_sdo.pop_front());
        end
        if (d_latch && !d_latch_q) begin
            d_pulses <= d_pulses + 1;
            if (q2_latch.size() == 0) unexpected("def_latch", cyc);
            else chk("def_latch_start", cyc, q2_latch.pop_front());
            d_latch_len <= 1;
        end else if (d_latch) begin
            d_latch_len <= d_latch_len + 1;
        end
        if (!d_latch && d_latch_q) chk("def_latch_width", d_latch_len, 2);
        if (d_ack) begin
            if (q2_ack.size() == 0) unexpected("def_ack", cyc);
            else chk("def_ack_cycle", cyc, q2_ack.pop_front());
        end
        d_sclk_q  <= d_sclk;
        d_latch_q <= d_latch;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int t0, t1;

    initial begin
        reset = 1'b1; row = '0; row_change = 1'b0; d_row = '0; d_row_change = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({ack, mem_rd, mem_addr, sdo, sclk, latch, busy}), 0);
        chk("reset_outputs_def", int'({d_ack, d_mem_rd, d_mem_addr, d_sdo, d_sclk, d_latch, d_busy}), 0);
        reset = 1'b0;
        @(negedge clk);

        // Single request with turn-timer handshake, then back-to-back second row
        t0 = cyc; row = 3'd5; row_change = 1'b1; push_row(t0, 5);
        repeat (20) @(negedge clk);
        chk("busy_wait_low", int'(busy), 1);
        row_change = 1'b0;
        @(negedge clk);
        chk("busy_idle", int'(busy), 0);
        t1 = cyc; row = 3'd0; row_change = 1'b1; push_row(t1, 0);
        repeat (20) @(negedge clk);
        row_change = 1'b0;
        repeat (3) @(negedge clk);

        // Row input changes mid-transfer; latched row must be used
        t0 = cyc; row = 3'd5; row_change = 1'b1; push_row(t0, 5);
        repeat (6) @(negedge clk);
        row = 3'd6;
        repeat (14) @(negedge clk);
        row_change = 1'b0;
        repeat (3) @(negedge clk);

        // Reset mid-transfer with request held: abort, then full restart
        t0 = cyc; row = 3'd5; row_change = 1'b1;
        q_rd_cyc.push_back(t0 + 1); q_rd_addr.push_back(23);
        q_rd_cyc.push_back(t0 + 5); q_rd_addr.push_back(22);
        q_rd_cyc.push_back(t0 + 9); q_rd_addr.push_back(21);
        q_sdo.push_back(7); q_sdo.push_back(6);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("post_reset_outputs", int'({ack, mem_rd, mem_addr, sdo, sclk, latch, busy}), 0);
        t1 = cyc; push_row(t1, 5);
        repeat (20) @(negedge clk);
        row_change = 1'b0;
        repeat (3) @(negedge clk);

        // Early drop of the request: transfer still completes and acks
        t0 = cyc; row = 3'd5; row_change = 1'b1; push_row(t0, 5);
        repeat (8) @(negedge clk);
        row_change = 1'b0;
        repeat (12) @(negedge clk);
        chk("early_busy_c20", int'(busy), 1);
        @(negedge clk);
        chk("early_idle_c21", int'(busy), 0);
        repeat (3) @(negedge clk);

        // Default configuration: 32 LEDs, SCLK_DIV=2, row 1
        t0 = cyc; d_row = 6'd1; d_row_change = 1'b1;
        for (int idx = 31; idx >= 0; idx--) q2_sdo.push_back(idx & 7);
        q2_latch.push_back(t0 + 193);
        q2_ack.push_back(t0 + 195);
        repeat (196) @(negedge clk);
        d_row_change = 1'b0;
        repeat (4) @(negedge clk);
        chk("def_sclk_rises", d_rises, 32);
        chk("def_latch_pulses", d_pulses, 1);
        chk("def_busy_idle", int'(d_busy), 0);

        chk("left_rd", q_rd_addr.size(), 0);
        chk("left_sdo", q_sdo.size(), 0);
        chk("left_latch", q_latch.size(), 0);
        chk("left_ack", q_ack.size(), 0);
        chk("left_def_sdo", q2_sdo.size(), 0);
        chk("left_def_ack", q2_ack.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
